// File: rtl/flu_wb_arbiter_if.sv
// Result-stream and writeback bundle between the fixed-latency units, the
// writeback collector and the scoreboard.
interface flu_wb_arbiter_if #(
    parameter int unsigned NR_FU       = 4,
    parameter int unsigned NR_WB_PORTS = 2,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned TRANS_ID_W  = 3
);
    localparam int unsigned SRC_W = $clog2(NR_FU);

    logic                                    flush_i;
    logic [NR_FU-1:0]                        fu_valid_i;
    logic [NR_FU-1:0]                        fu_ready_o;
    logic [NR_FU-1:0][DATA_W-1:0]            fu_result_i;
    logic [NR_FU-1:0][TRANS_ID_W-1:0]        fu_trans_id_i;
    logic [NR_FU-1:0]                        fu_ex_valid_i;
    logic [NR_WB_PORTS-1:0]                  wb_valid_o;
    logic [NR_WB_PORTS-1:0][DATA_W-1:0]      wb_result_o;
    logic [NR_WB_PORTS-1:0][TRANS_ID_W-1:0]  wb_trans_id_o;
    logic [NR_WB_PORTS-1:0]                  wb_ex_valid_o;
    logic [NR_WB_PORTS-1:0][SRC_W-1:0]       wb_src_o;
    logic                                    busy_o;

    modport slave (
        input  flush_i, fu_valid_i, fu_result_i, fu_trans_id_i, fu_ex_valid_i,
        output fu_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_ex_valid_o,
        output wb_src_o, busy_o
    );

    modport master (
        output flush_i, fu_valid_i, fu_result_i, fu_trans_id_i, fu_ex_valid_i,
        input  fu_ready_o, wb_valid_o, wb_result_o, wb_trans_id_o, wb_ex_valid_o,
        input  wb_src_o, busy_o
    );
endinterface

// File: rtl/flu_wb_arbiter.sv
// Writeback collector for the fixed-latency unit cluster: one small FIFO per
// result channel, drained onto NR_WB_PORTS scoreboard ports in round-robin order.
module flu_wb_arbiter #(
    parameter int unsigned NR_FU       = 4,
    parameter int unsigned NR_WB_PORTS = 2,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned TRANS_ID_W  = 3,
    parameter int unsigned BUF_DEPTH   = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    flu_wb_arbiter_if.slave bus
);
    localparam int unsigned SRC_W = $clog2(NR_FU);
    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    if (NR_WB_PORTS > NR_FU) begin : g_bad_ports
        $error("flu_wb_arbiter: NR_WB_PORTS must not exceed NR_FU");
    end
    if (BUF_DEPTH < 1) begin : g_bad_depth
        $error("flu_wb_arbiter: BUF_DEPTH must be at least 1");
    end

    typedef struct packed {
        logic [DATA_W-1:0]     result;
        logic [TRANS_ID_W-1:0] trans_id;
        logic                  ex_valid;
    } entry_t;

    entry_t           mem_q    [NR_FU][BUF_DEPTH];
    entry_t           head     [NR_FU];
    logic [PTR_W-1:0] rd_ptr_q [NR_FU];
    logic [PTR_W-1:0] wr_ptr_q [NR_FU];
    logic [CNT_W-1:0] cnt_q    [NR_FU];
    logic [SRC_W-1:0] rr_q, rr_d;

    logic [NR_FU-1:0] full, empty, push, pop;

    logic [NR_WB_PORTS-1:0]                 wb_valid;
    logic [NR_WB_PORTS-1:0][DATA_W-1:0]     wb_result;
    logic [NR_WB_PORTS-1:0][TRANS_ID_W-1:0] wb_trans_id;
    logic [NR_WB_PORTS-1:0]                 wb_ex_valid;
    logic [NR_WB_PORTS-1:0][SRC_W-1:0]      wb_src;

    logic [SRC_W:0]   scan_sum;
    logic [SRC_W-1:0] scan_ch;
    int               granted;
    logic             dup_grant;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready is taken from registered occupancy only, so a full FIFO never
    // accepts even in a cycle where its head is being written back.
    always_comb begin
        for (int i = 0; i < NR_FU; i++) begin
            full[i]  = (cnt_q[i] == CNT_W'(BUF_DEPTH));
            empty[i] = (cnt_q[i] == '0);
            push[i]  = bus.fu_valid_i[i] && !full[i] && !bus.flush_i;
            head[i]  = mem_q[i][rd_ptr_q[i]];
        end
    end

    // Walk the channels starting at rr_q; the k-th non-empty one lands on port k.
    always_comb begin
        pop         = '0;
        rr_d        = rr_q;
        wb_valid    = '0;
        wb_result   = '0;
        wb_trans_id = '0;
        wb_ex_valid = '0;
        wb_src      = '0;
        granted     = 0;
        scan_sum    = '0;
        scan_ch     = '0;
        for (int off = 0; off < NR_FU; off++) begin
            scan_sum = {1'b0, rr_q} + (SRC_W + 1)'(off);
            if (scan_sum >= (SRC_W + 1)'(NR_FU)) begin
                scan_sum = scan_sum - (SRC_W + 1)'(NR_FU);
            end
            scan_ch = scan_sum[SRC_W-1:0];
            for (int k = 0; k < NR_WB_PORTS; k++) begin
                if (!bus.flush_i && !empty[scan_ch] && granted == k) begin
                    wb_valid[k]    = 1'b1;
                    wb_result[k]   = head[scan_ch].result;
                    wb_trans_id[k] = head[scan_ch].trans_id;
                    wb_ex_valid[k] = head[scan_ch].ex_valid;
                    wb_src[k]      = scan_ch;
                    pop[scan_ch]   = 1'b1;
                    rr_d = (scan_ch == SRC_W'(NR_FU - 1)) ? '0 : scan_ch + 1'b1;
                end
            end
            if (!empty[scan_ch]) begin
                granted = granted + 1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= '0;
            for (int i = 0; i < NR_FU; i++) begin
                cnt_q[i]    <= '0;
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
            end
        end else if (bus.flush_i) begin
            for (int i = 0; i < NR_FU; i++) begin
                cnt_q[i]    <= '0;
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
            end
        end else begin
            rr_q <= rr_d;
            for (int i = 0; i < NR_FU; i++) begin
                if (push[i]) wr_ptr_q[i] <= ptr_inc(wr_ptr_q[i]);
                if (pop[i])  rd_ptr_q[i] <= ptr_inc(rd_ptr_q[i]);
                if (push[i] && !pop[i]) begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end else if (!push[i] && pop[i]) begin
                    cnt_q[i] <= cnt_q[i] - 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: an entry is only visible once its count says so.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_FU; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= entry_t'{
                    result:   bus.fu_result_i[i],
                    trans_id: bus.fu_trans_id_i[i],
                    ex_valid: bus.fu_ex_valid_i[i]
                };
            end
        end
    end

    assign bus.fu_ready_o    = ~full;
    assign bus.busy_o        = |(~empty);
    assign bus.wb_valid_o    = wb_valid;
    assign bus.wb_result_o   = wb_result;
    assign bus.wb_trans_id_o = wb_trans_id;
    assign bus.wb_ex_valid_o = wb_ex_valid;
    assign bus.wb_src_o      = wb_src;

    always_comb begin
        dup_grant = 1'b0;
        for (int a = 0; a < NR_WB_PORTS; a++) begin
            for (int b = a + 1; b < NR_WB_PORTS; b++) begin
                if (wb_valid[a] && wb_valid[b] && wb_src[a] == wb_src[b]) dup_grant = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NR_FU; i++) begin : g_chk
        a_no_empty_pop: assert property (
            @(posedge clk_i) disable iff (!rst_ni) pop[i] |-> !empty[i]);
    end

    a_no_dup_grant: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !dup_grant);

endmodule

// File: tb/tb_flu_wb_arbiter.sv
// Bench for flu_wb_arbiter: directed vector table, randomized traffic against a
// queue-based model, and an asynchronous reset in the middle of a burst.
module tb_flu_wb_arbiter;
    localparam int NR_FU       = 4;
    localparam int NR_WB_PORTS = 2;
    localparam int DATA_W      = 64;
    localparam int TRANS_ID_W  = 3;
    localparam int BUF_DEPTH   = 2;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    int   checks = 0;
    int   errors = 0;

    flu_wb_arbiter_if #(
        .NR_FU(NR_FU), .NR_WB_PORTS(NR_WB_PORTS), .DATA_W(DATA_W), .TRANS_ID_W(TRANS_ID_W)
    ) bus ();

    flu_wb_arbiter #(
        .NR_FU(NR_FU), .NR_WB_PORTS(NR_WB_PORTS), .DATA_W(DATA_W),
        .TRANS_ID_W(TRANS_ID_W), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DATA_W-1:0]     result;
        logic [TRANS_ID_W-1:0] id;
        logic                  ex;
    } ent_t;

    // Model: one queue per channel, a round-robin start index and this cycle's grants.
    ent_t mq [NR_FU][$];
    int   m_rr;
    int   m_gnt [$];

    typedef struct {
        logic [NR_FU-1:0]       valid;
        logic                   flush;
        logic [DATA_W-1:0]      data;
        int                     id;
        logic                   ex;
        logic [NR_WB_PORTS-1:0] exp_wb;
        int                     exp_src0;
        int                     exp_src1;
        logic [NR_FU-1:0]       exp_ready;
        logic                   exp_busy;
    } vec_t;

    vec_t vecs [$];

    function automatic void addVec(logic [NR_FU-1:0] valid, logic flush, logic [DATA_W-1:0] data,
                                   int id, logic ex, logic [NR_WB_PORTS-1:0] exp_wb, int s0, int s1,
                                   logic [NR_FU-1:0] exp_ready, logic exp_busy);
        vec_t v;
        v.valid = valid; v.flush = flush; v.data = data; v.id = id; v.ex = ex;
        v.exp_wb = exp_wb; v.exp_src0 = s0; v.exp_src1 = s1;
        v.exp_ready = exp_ready; v.exp_busy = exp_busy;
        vecs.push_back(v);
    endfunction

    task automatic checkVal(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NR_FU; i++) mq[i].delete();
        m_rr = 0;
        m_gnt.delete();
    endtask

    task automatic applyStimulus(input logic [NR_FU-1:0] valid,
                                 input logic [NR_FU-1:0][DATA_W-1:0] res,
                                 input logic [NR_FU-1:0][TRANS_ID_W-1:0] ids,
                                 input logic [NR_FU-1:0] ex,
                                 input logic flush);
        bus.fu_valid_i    = valid;
        bus.fu_result_i   = res;
        bus.fu_trans_id_i = ids;
        bus.fu_ex_valid_i = ex;
        bus.flush_i       = flush;
        @(negedge clk_i);
    endtask

    // Compare every output against what the queues say should be visible now.
    task automatic checkOutput();
        logic [NR_FU-1:0] exp_ready;
        logic             exp_busy;
        int               ch;
        ent_t             e;
        exp_ready = '0;
        exp_busy  = 1'b0;
        for (int i = 0; i < NR_FU; i++) begin
            exp_ready[i] = (mq[i].size() < BUF_DEPTH);
            if (mq[i].size() > 0) exp_busy = 1'b1;
        end
        m_gnt.delete();
        for (int off = 0; off < NR_FU; off++) begin
            ch = (m_rr + off) % NR_FU;
            if (!bus.flush_i && mq[ch].size() > 0 && m_gnt.size() < NR_WB_PORTS) m_gnt.push_back(ch);
        end
        checkVal("fu_ready", 64'(bus.fu_ready_o), 64'(exp_ready));
        checkVal("busy", 64'(bus.busy_o), 64'(exp_busy));
        for (int k = 0; k < NR_WB_PORTS; k++) begin
            if (k < m_gnt.size()) begin
                ch = m_gnt[k];
                e  = mq[ch][0];
                checkVal($sformatf("wb%0d_valid", k), 64'(bus.wb_valid_o[k]), 64'd1);
                checkVal($sformatf("wb%0d_result", k), bus.wb_result_o[k], e.result);
                checkVal($sformatf("wb%0d_id", k), 64'(bus.wb_trans_id_o[k]), 64'(e.id));
                checkVal($sformatf("wb%0d_ex", k), 64'(bus.wb_ex_valid_o[k]), 64'(e.ex));
                checkVal($sformatf("wb%0d_src", k), 64'(bus.wb_src_o[k]), 64'(ch));
            end else begin
                checkVal($sformatf("wb%0d_valid", k), 64'(bus.wb_valid_o[k]), 64'd0);
                checkVal($sformatf("wb%0d_result", k), bus.wb_result_o[k], 64'd0);
                checkVal($sformatf("wb%0d_id", k), 64'(bus.wb_trans_id_o[k]), 64'd0);
                checkVal($sformatf("wb%0d_ex", k), 64'(bus.wb_ex_valid_o[k]), 64'd0);
                checkVal($sformatf("wb%0d_src", k), 64'(bus.wb_src_o[k]), 64'd0);
            end
        end
    endtask

    // Advance the model across the clock edge, then move to just after it.
    task automatic finishCycle();
        logic [NR_FU-1:0] acc;
        ent_t             e;
        if (bus.flush_i) begin
            for (int i = 0; i < NR_FU; i++) mq[i].delete();
        end else begin
            for (int i = 0; i < NR_FU; i++) acc[i] = bus.fu_valid_i[i] && (mq[i].size() < BUF_DEPTH);
            foreach (m_gnt[g]) void'(mq[m_gnt[g]].pop_front());
            if (m_gnt.size() > 0) m_rr = (m_gnt[m_gnt.size() - 1] + 1) % NR_FU;
            for (int i = 0; i < NR_FU; i++) begin
                if (acc[i]) begin
                    e.result = bus.fu_result_i[i];
                    e.id     = bus.fu_trans_id_i[i];
                    e.ex     = bus.fu_ex_valid_i[i];
                    mq[i].push_back(e);
                end
            end
        end
        m_gnt.delete();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NR_FU-1:0][DATA_W-1:0]     res;
        logic [NR_FU-1:0][TRANS_ID_W-1:0] ids;
        logic [NR_FU-1:0]                 exv;
        vec_t                             v;

        // valid flush data id ex | wb src0 src1 ready busy   (id for channel c is id+c)
        addVec(4'b0100, 0, 64'hDEAD, 3, 0,  2'b00, 0, 0, 4'b1111, 0);
        addVec(4'b0000, 0, 64'h0,    0, 0,  2'b01, 2, 0, 4'b1111, 1);
        addVec(4'b0000, 0, 64'h0,    0, 0,  2'b00, 0, 0, 4'b1111, 0);
        addVec(4'b1000, 0, 64'h33,   0, 0,  2'b00, 0, 0, 4'b1111, 0);
        addVec(4'b0000, 0, 64'h0,    0, 0,  2'b01, 3, 0, 4'b1111, 1);
        addVec(4'b1111, 0, 64'h55,   0, 1,  2'b00, 0, 0, 4'b1111, 0);
        addVec(4'b0000, 0, 64'h0,    0, 0,  2'b11, 0, 1, 4'b1111, 1);
        addVec(4'b0000, 0, 64'h0,    0, 0,  2'b11, 2, 3, 4'b1111, 1);
        addVec(4'b0000, 0, 64'h0,    0, 0,  2'b00, 0, 0, 4'b1111, 0);
        addVec(4'b0001, 0, 64'h99,   0, 0,  2'b00, 0, 0, 4'b1111, 0);
        addVec(4'b0111, 0, 64'hA,    1, 0,  2'b01, 0, 0, 4'b1111, 1);
        addVec(4'b0001, 0, 64'hB,    2, 0,  2'b11, 1, 2, 4'b1111, 1);
        addVec(4'b0001, 0, 64'hC,    3, 0,  2'b01, 0, 0, 4'b1110, 1);
        addVec(4'b0000, 0, 64'h0,    0, 0,  2'b01, 0, 0, 4'b1111, 1);
        addVec(4'b0000, 0, 64'h0,    0, 0,  2'b00, 0, 0, 4'b1111, 0);
        addVec(4'b0010, 0, 64'h15,   0, 0,  2'b00, 0, 0, 4'b1111, 0);
        addVec(4'b1110, 0, 64'h16,   0, 0,  2'b01, 1, 0, 4'b1111, 1);
        addVec(4'b0010, 0, 64'h17,   0, 0,  2'b11, 2, 3, 4'b1111, 1);
        addVec(4'b0010, 0, 64'h18,   0, 0,  2'b01, 1, 0, 4'b1101, 1);
        addVec(4'b0000, 0, 64'h0,    0, 0,  2'b01, 1, 0, 4'b1111, 1);
        addVec(4'b0000, 0, 64'h0,    0, 0,  2'b00, 0, 0, 4'b1111, 0);
        addVec(4'b0111, 0, 64'h21,   0, 0,  2'b00, 0, 0, 4'b1111, 0);
        addVec(4'b1000, 1, 64'h22,   0, 0,  2'b00, 0, 0, 4'b1111, 1);
        addVec(4'b0000, 0, 64'h0,    0, 0,  2'b00, 0, 0, 4'b1111, 0);
        addVec(4'b1111, 0, 64'h24,   0, 0,  2'b00, 0, 0, 4'b1111, 0);
        addVec(4'b0000, 0, 64'h0,    0, 0,  2'b11, 2, 3, 4'b1111, 1);
        addVec(4'b0000, 0, 64'h0,    0, 0,  2'b11, 0, 1, 4'b1111, 1);
        addVec(4'b0000, 0, 64'h0,    0, 0,  2'b00, 0, 0, 4'b1111, 0);

        modelReset();
        applyStimulus('0, '0, '0, '0, 1'b0);
        @(negedge clk_i);
        checkOutput();
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        $display("[TB] directed vector table");
        for (int r = 0; r < vecs.size(); r++) begin
            v = vecs[r];
            for (int c = 0; c < NR_FU; c++) begin
                res[c] = v.data;
                ids[c] = TRANS_ID_W'(v.id + c);
                exv[c] = v.ex;
            end
            applyStimulus(v.valid, res, ids, exv, v.flush);
            checkOutput();
            checkVal($sformatf("row%0d_wb_valid", r), 64'(bus.wb_valid_o), 64'(v.exp_wb));
            if (v.exp_wb[0]) checkVal($sformatf("row%0d_src0", r), 64'(bus.wb_src_o[0]), 64'(v.exp_src0));
            if (v.exp_wb[1]) checkVal($sformatf("row%0d_src1", r), 64'(bus.wb_src_o[1]), 64'(v.exp_src1));
            checkVal($sformatf("row%0d_ready", r), 64'(bus.fu_ready_o), 64'(v.exp_ready));
            checkVal($sformatf("row%0d_busy", r), 64'(bus.busy_o), 64'(v.exp_busy));
            finishCycle();
        end

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NR_FU; c++) begin
                res[c] = {$urandom(), $urandom()};
                ids[c] = TRANS_ID_W'($urandom_range(0, (1 << TRANS_ID_W) - 1));
                exv[c] = 1'($urandom_range(0, 1));
            end
            applyStimulus(NR_FU'($urandom_range(0, (1 << NR_FU) - 1)), res, ids, exv,
                          ($urandom_range(0, 15) == 0));
            checkOutput();
            finishCycle();
        end

        $display("[TB] asynchronous reset mid-burst");
        for (int c = 0; c < NR_FU; c++) begin
            res[c] = 64'h5000 + 64'(c);
            ids[c] = TRANS_ID_W'(c);
            exv[c] = 1'b0;
        end
        applyStimulus('1, res, ids, exv, 1'b0);
        checkOutput();
        finishCycle();
        bus.fu_valid_i = '0;
        #2;
        rst_ni = 1'b0;
        #1;
        checkVal("rst_wb_valid", 64'(bus.wb_valid_o), 64'd0);
        checkVal("rst_wb_result0", bus.wb_result_o[0], 64'd0);
        checkVal("rst_wb_id", 64'(bus.wb_trans_id_o), 64'd0);
        checkVal("rst_wb_src", 64'(bus.wb_src_o), 64'd0);
        checkVal("rst_busy", 64'(bus.busy_o), 64'd0);
        checkVal("rst_ready", 64'(bus.fu_ready_o), 64'hF);
        modelReset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        res = '0;
        ids = '0;
        res[1] = 64'h1234;
        ids[1] = 3'd6;
        applyStimulus(4'b0010, res, ids, '0, 1'b0);
        checkOutput();
        finishCycle();
        applyStimulus('0, '0, '0, '0, 1'b0);
        checkOutput();
        checkVal("post_rst_result", bus.wb_result_o[0], 64'h1234);
        checkVal("post_rst_id", 64'(bus.wb_trans_id_o[0]), 64'd6);
        checkVal("post_rst_src", 64'(bus.wb_src_o[0]), 64'd1);
        finishCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
